wshb_arbiter2: RTL and testbench
================================

Name: wshb_arbiter2

Overview:
- Two-master, one-slave arbiter for the SDRAM Wishbone bus (classic cycles, one outstanding access).
- M0 is the video framebuffer reader and has priority; M1 is the pattern/mire writer.
- M1 is guaranteed bandwidth by bounding any grant to MAX_BURST acks while the other master is waiting.
- Sits in Top between the two masters and the SDRAM controller's Wishbone slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width = DW/8.
- MAX_BURST, 16, max acks in one grant while the other master requests (>=1).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous reset, active low.
- m0_cyc, m0_stb, m0_we  in  1 each  M0 (video) request.
- m0_adr  in  AW  M0 address.
- m0_dat_w  in  DW  M0 write data.
- m0_sel  in  DW/8  M0 byte select.
- m0_ack  out  1  M0 acknowledge.
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel  in  (as M0)  M1 (mire) request.
- m1_ack  out  1  M1 acknowledge.
- m_dat_r  out  DW  slave read data, broadcast to both masters.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  AW  to slave.
- s_dat_w  out  DW  to slave.
- s_sel  out  DW/8  to slave.
- s_ack  in  1  slave acknowledge.
- s_dat_r  in  DW  slave read data.
- grant  out  2  registered one-hot grant; bit0 = M0, bit1 = M1, 00 = none.

Behaviour:
- Reset (sys_rst_n=0 at an edge): state IDLE, grant=00, burst counter=0. While grant=00: s_cyc=s_stb=0, m0_ack=m1_ack=0.
- Reset mid-access: bus is dropped at that edge with no ack. Masters restart after reset.
- States: IDLE, GNT0, GNT1, PREEMPT. grant is decoded from state: GNT0->01, GNT1->10, others->00.
- IDLE:
  - m0_cyc=1 -> GNT0 (M0 wins ties).
  - else m1_cyc=1 -> GNT1.
  - else stay.
  - Grant is registered: a request seen at edge n is visible on s_* from cycle n+1. Minimum latency is 1 cycle.
- GNTx (x granted):
  - s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel = mx_* combinationally.
  - mx_ack = s_ack & s_cyc. The other master's ack = 0.
  - m_dat_r = s_dat_r always.
- Burst counter:
  - Clears on entering any GNT state.
  - Increments on each s_ack while in GNT state.
  - Saturates at MAX_BURST.
- Leaving GNTx:
  - mx_cyc=0 -> IDLE. There is one dead cycle; re-arbitration happens at the next edge.
  - Else, other master's cyc=1 AND counter reaches MAX_BURST (the ack that makes it MAX_BURST) -> PREEMPT.
  - Else stay.
- PREEMPT:
  - Exactly 1 cycle; s_cyc=0 and no acks.
  - Then GNT of the other master unconditionally if its cyc is still 1, else IDLE.
  - The preempted master keeps cyc/stb high and simply sees no ack. This is legal classic Wishbone. It is re-served when the grant returns.
- No fairness pointer beyond the counter.
  - The M0 tie priority in IDLE is intentional: video underrun is worse than a slow mire.
  - Bound: M1 waits at most MAX_BURST acks plus 1 PREEMPT cycle while M0 streams.
- Ack outside a grant (s_ack while s_cyc=0) is ignored and does not count.
- A master dropping cyc in the same cycle as its last ack is served normally; the FSM goes to IDLE next edge.
- MAX_BURST=1: alternate every ack when both masters request continuously.

Test Plan:
- Reset: hold sys_rst_n=0 for 3 cycles with m0_cyc=m1_cyc=1 -> grant=00, s_cyc=0, no acks; at the first edge with sys_rst_n=1, grant=01 visible the following cycle.
- Single master: M1 only, 4 writes to adr 0x100..0x10C, slave acks 1 cycle after stb -> s_adr/s_dat_w track M1, m1_ack pulses 4 times, m0_ack=0, grant=10 then 00 one cycle after m1_cyc falls.
- Tie: m0_cyc and m1_cyc rise together from IDLE -> grant=01.
- Preemption: M0 streams 40 reads, M1 requests continuously, MAX_BURST=16 -> M0 gets 16 acks, 1 PREEMPT cycle (s_cyc=0), M1 gets up to 16 acks, then back to M0. M0 read data order and count (40) are preserved.
- Early release: M0 drops cyc after 5 acks while M1 waits -> IDLE for 1 cycle, then grant=10. No PREEMPT occurs.
- Reset mid-burst: assert sys_rst_n=0 during GNT1 with stb pending -> at that edge grant=00 and s_cyc=0, m1_ack never asserted for the pending access; counter is 0 after reset.

Source files
------------

// File: rtl/wshb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wshb_arbiter2
// Purpose  : Two-master / one-slave classic Wishbone arbiter for the SDRAM
//            port. M0 (video framebuffer reader) has priority. M1 (pattern
//            writer) is guaranteed bandwidth because a grant is cut after
//            MAX_BURST acks whenever the other master is waiting.
// Ports    : sys_clk, sys_rst_n (sync, active low)
//            m0_* / m1_*  : master request buses in, mX_ack out
//            m_dat_r      : slave read data broadcast to both masters
//            s_*          : slave bus out, s_ack / s_dat_r in
//            grant        : registered one-hot grant (bit0 M0, bit1 M1)
// Revision : 1.0  initial release
// ============================================================================
module wshb_arbiter2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic [DW-1:0]   m_dat_r,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_r,
  output logic [1:0]      grant
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0]   MAX_EXT = (CW+1)'(MAX_BURST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    PREEMPT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          next_m1_q, next_m1_d;  // PREEMPT target: 1 = hand bus to M1
  logic [1:0]    grant_q, grant_d;

  logic          ack_in;
  logic          own_cyc;
  logic          other_cyc;
  logic [CW:0]   cnt_inc;
  logic          burst_done;

  // Slave-side mux and ack routing follow the current (registered) state.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        m0_ack  = s_ack & m0_cyc;
      end
      GNT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        m1_ack  = s_ack & m1_cyc;
      end
      default: ;
    endcase
  end

  assign m_dat_r = s_dat_r;

  // Acks seen while the bus is not driven are stray and never counted.
  assign ack_in    = s_ack & s_cyc;
  assign own_cyc   = (state_q == GNT1) ? m1_cyc : m0_cyc;
  assign other_cyc = (state_q == GNT1) ? m0_cyc : m1_cyc;
  assign cnt_inc   = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  // '>=' also catches a counter that saturated before the other master
  // arrived: the next completed access then ends the grant.
  assign burst_done = ack_in & other_cyc & (cnt_inc >= MAX_EXT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    next_m1_d = next_m1_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc) state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (ack_in && (cnt_q != MAX_CNT)) cnt_d = cnt_inc[CW-1:0];
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (burst_done) begin
          state_d   = PREEMPT;
          next_m1_d = (state_q == GNT0);
        end
      end
      PREEMPT: begin
        if (next_m1_q) state_d = m1_cyc ? GNT1 : IDLE;
        else           state_d = m0_cyc ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (((state_d == GNT0) || (state_d == GNT1)) && (state_d != state_q)) cnt_d = '0;
  end

  always_comb begin
    case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      next_m1_q <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      next_m1_q <= next_m1_d;
      grant_q   <= grant_d;
    end
  end

  assign grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_arbiter2
// Purpose  : Self-checking bench for wshb_arbiter2 (MAX_BURST = 16).
//            Cycle vectors from a table, then master/slave sequences for
//            single-master traffic, preemption, early release and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_wshb_arbiter2;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_dat_w;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_dat_w;
  logic [3:0]  m1_sel;
  logic [31:0] m_dat_r;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  int n_chk = 0;
  int n_bad = 0;

  bit exp_log[$];
  bit got_log[$];

  always #5 clk = ~clk;

  wshb_arbiter2 #(.AW(32), .DW(32), .MAX_BURST(16)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack),
    .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
    .grant(grant)
  );

  typedef struct {
    logic        rst_n;
    logic        c0;
    logic        c1;
    logic        ack;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic        e_a0;
    logic        e_a1;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic push_n(input bit owner, input int n);
    for (int i = 0; i < n; i++) exp_log.push_back(owner);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat_w = 0; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_adr = 0; m1_dat_w = 0; m1_sel = 4'h3;
    s_ack = 0; s_dat_r = 0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    sys_rst_n = 0;
    @(posedge clk); #1;
    sys_rst_n = 1;
  endtask

  // M0 performs n0 reads, M1 n1 writes; a slave acks one cycle after stb.
  task automatic run(input string tag, input int n0, input int n1,
                     input logic [1:0] exp_first, input int exp_gap);
    int c0, c1, cyc, gap, mis;
    bit started;
    logic [1:0] first_g;
    logic nack;
    logic [31:0] ndat;
    bit last_owner;
    c0 = 0; c1 = 0; cyc = 0; gap = 0; mis = 0;
    started = 0; first_g = 2'b00; nack = 0; ndat = 0;
    got_log.delete();
    while (((c0 < n0) || (c1 < n1)) && (cyc < 2000)) begin
      m0_cyc = (c0 < n0); m0_stb = m0_cyc; m0_we = 0;
      m0_adr = 32'h1000 + 32'(4 * c0);
      m1_cyc = (c1 < n1); m1_stb = m1_cyc; m1_we = 1;
      m1_adr = 32'h100 + 32'(4 * c1);
      m1_dat_w = 32'hA000 + 32'(c1);
      s_ack = nack; s_dat_r = ndat;
      #2;
      if (grant != 2'b00) begin
        if (!started) first_g = grant;
        started = 1;
      end else begin
        if (started) gap++;
        check({tag, "_bus_idle"}, {61'd0, s_cyc, m0_ack, m1_ack}, 64'd0);
      end
      if (m0_ack) begin
        check({tag, "_m0_rdata"}, m_dat_r, rd_pattern(32'h1000 + 32'(4 * c0)));
        check({tag, "_m0_we"}, s_we, 0);
        got_log.push_back(1'b0);
        c0++;
      end
      if (m1_ack) begin
        check({tag, "_m1_adr"}, s_adr, 32'h100 + 32'(4 * c1));
        check({tag, "_m1_wdat_sel"}, {s_we, s_sel, s_dat_w}, {1'b1, 4'h3, 32'hA000 + 32'(c1)});
        got_log.push_back(1'b1);
        c1++;
      end
      nack = s_cyc & s_stb & ~s_ack;
      ndat = rd_pattern(s_adr);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_no_timeout"}, cyc < 2000, 1);
    check({tag, "_first_grant"}, first_g, exp_first);
    check({tag, "_gap_cycles"}, gap, exp_gap);
    check({tag, "_ack_count"}, got_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < got_log.size(); i++)
      if (got_log[i] != exp_log[i]) mis++;
    check({tag, "_ack_order_errs"}, mis, 0);
    last_owner = (exp_log.size() > 0) ? exp_log[exp_log.size()-1] : 1'b0;
    idle_inputs();
    #2;
    check({tag, "_grant_after_drop"}, grant, last_owner ? 2'b10 : 2'b01);
    @(posedge clk); #3;
    check({tag, "_grant_idle"}, {s_cyc, grant}, 3'b000);
    exp_log.delete();
  endtask

  initial begin
    // rst_n c0 c1 ack | grant scyc a0 a1 adr
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h1000};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h1000};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h2000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h2000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h1000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h1000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};

    idle_inputs();
    sys_rst_n = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      sys_rst_n = tbl[i].rst_n;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0; m0_adr = 32'h1000;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1; m1_adr = 32'h2000;
      s_ack  = tbl[i].ack;
      #2;
      check($sformatf("vec%0d", i),
            {27'd0, grant, s_cyc, m0_ack, m1_ack, s_adr},
            {27'd0, tbl[i].e_grant, tbl[i].e_scyc, tbl[i].e_a0, tbl[i].e_a1, tbl[i].e_adr});
      @(posedge clk); #1;
    end

    // Single master: M1 writes 0x100..0x10C.
    reset_pulse();
    push_n(1'b1, 4);
    run("single_m1", 0, 4, 2'b10, 0);

    // Preemption: M0 streams 40 reads against continuously requesting M1.
    reset_pulse();
    push_n(1'b0, 16); push_n(1'b1, 16); push_n(1'b0, 16); push_n(1'b1, 4); push_n(1'b0, 8);
    run("preempt", 40, 20, 2'b01, 4);

    // Early release: M0 leaves after 5 acks, M1 follows after one idle cycle.
    reset_pulse();
    push_n(1'b0, 5); push_n(1'b1, 3);
    run("early_rel", 5, 3, 2'b01, 1);

    // Reset while an M1 access is outstanding.
    reset_pulse();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h300; m1_dat_w = 32'h55;
    @(posedge clk); #1;
    #2;
    check("rst_mid_grant", {s_cyc, m1_ack, grant}, 4'b1010);
    @(posedge clk); #1;
    s_ack = 1;
    #2;
    check("rst_mid_first_ack", m1_ack, 1);
    @(posedge clk); #1;
    s_ack = 0; m1_adr = 32'h304;
    #2;
    check("rst_mid_pending", {s_cyc, s_stb, m1_ack, grant}, 5'b11010);
    sys_rst_n = 0;
    @(posedge clk); #1;
    s_ack = 1;
    #2;
    check("rst_mid_dropped", {s_cyc, m1_ack, m0_ack, grant}, 5'b00000);
    check("rst_mid_counter", 64'(dut.cnt_q), 0);
    idle_inputs();
    sys_rst_n = 1;
    @(posedge clk); #3;
    check("rst_mid_after", {s_cyc, grant}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
